// File: rtl/glob_acc_et_maxpool.sv
// glob_acc_et_maxpool
// Per-neuron datapath behind the global-accumulator control pipeline.
// Partial sums are accumulated with saturation, and each pooled row value is
// offered to a running max that remembers its row index. An early-termination
// (ET) flag compares the accumulator against a threshold. Each pooling window
// publishes its result through a valid/ready output register.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module glob_acc_et_maxpool #(
  parameter int IN_W  = 12,
  parameter int ACC_W = 16,
  parameter int RI_W  = 6
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic signed [IN_W-1:0]  psum_in,
  input  logic                    glbctr_latch,
  input  logic                    mxpl_latch,
  input  logic                    mxpl_clr,
  input  logic        [RI_W-1:0]  ri_in,
  input  logic                    et_l1_en,
  input  logic                    et_l1_clr,
  input  logic signed [ACC_W-1:0] et_thr,
  input  logic                    et_l3_en,
  input  logic                    compute_done,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_max,
  output logic        [RI_W-1:0]  out_ri,
  output logic                    et_flag,
  output logic                    et_stop,
  output logic                    ovf_err
);

  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] maxVal_q, maxVal_d;
  logic        [RI_W-1:0]  maxRi_q, maxRi_d;
  logic                    maxVld_q, maxVld_d;
  logic                    etFlag_q, etFlag_d;
  logic                    etStop_q, etStop_d;
  logic                    outValid_q, outValid_d;
  logic signed [ACC_W-1:0] outMax_q, outMax_d;
  logic        [RI_W-1:0]  outRi_q, outRi_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W:0]   sumWide;
  logic signed [ACC_W-1:0] cand;
  logic signed [ACC_W-1:0] maxBase;
  logic                    vldBase;
  logic                    etCond;
  logic                    canLoad;

  // Candidate accumulator value: one extra bit catches overflow, which is
  // then clamped to the representable range instead of wrapping.
  always_comb begin
    sumWide = $signed({acc_q[ACC_W-1], acc_q})
            + $signed({{(ACC_W+1-IN_W){psum_in[IN_W-1]}}, psum_in});
    cand = acc_q;
    if (glbctr_latch) begin
      if (sumWide[ACC_W] != sumWide[ACC_W-1]) begin
        cand = sumWide[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        cand = sumWide[ACC_W-1:0];
      end
    end
    acc_d = mxpl_latch ? '0 : cand;
  end

  // Running max: a clear applies first, so a same-cycle latch starts a new
  // window. On a tie the earlier row is kept.
  always_comb begin
    maxBase  = mxpl_clr ? ACC_MIN : maxVal_q;
    vldBase  = mxpl_clr ? 1'b0 : maxVld_q;
    maxVal_d = maxBase;
    maxRi_d  = maxRi_q;
    maxVld_d = vldBase | mxpl_latch;
    if (mxpl_latch && (!vldBase || (cand > maxBase))) begin
      maxVal_d = cand;
      maxRi_d  = ri_in;
    end
  end

  // ET flag: a clear together with an enable reloads the flag from the
  // condition, while an enable alone only accumulates into it. The stop pulse
  // is based on the flag value held before this cycle.
  always_comb begin
    etCond   = (cand < et_thr);
    etFlag_d = etFlag_q;
    if (et_l1_clr && et_l1_en) begin
      etFlag_d = etCond;
    end else if (et_l1_clr) begin
      etFlag_d = 1'b0;
    end else if (et_l1_en) begin
      etFlag_d = etFlag_q | etCond;
    end
    etStop_d = et_l3_en & etFlag_q;
  end

  // Output register: a result loads when the slot is empty or is being
  // accepted in the same cycle. Otherwise the new result is dropped and the
  // overflow sticks.
  always_comb begin
    canLoad    = !outValid_q || out_ready;
    outValid_d = outValid_q;
    outMax_d   = outMax_q;
    outRi_d    = outRi_q;
    ovf_d      = ovf_q;
    if (compute_done) begin
      if (canLoad) begin
        outValid_d = 1'b1;
        outMax_d   = maxVld_d ? maxVal_d : ACC_MIN;
        outRi_d    = maxVld_d ? maxRi_d : '0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset; the max starts most-negative.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc_q      <= '0;
      maxVal_q   <= ACC_MIN;
      maxRi_q    <= '0;
      maxVld_q   <= 1'b0;
      etFlag_q   <= 1'b0;
      etStop_q   <= 1'b0;
      outValid_q <= 1'b0;
      outMax_q   <= '0;
      outRi_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      maxVal_q   <= maxVal_d;
      maxRi_q    <= maxRi_d;
      maxVld_q   <= maxVld_d;
      etFlag_q   <= etFlag_d;
      etStop_q   <= etStop_d;
      outValid_q <= outValid_d;
      outMax_q   <= outMax_d;
      outRi_q    <= outRi_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_max   = outMax_q;
  assign out_ri    = outRi_q;
  assign et_flag   = etFlag_q;
  assign et_stop   = etStop_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_glob_acc_et_maxpool.sv
// tb_glob_acc_et_maxpool
// Scoreboard bench. The driver applies one stimulus per cycle and advances a
// list-based reference model. The model pushes the expected per-cycle status
// and every expected published result into queues. A monitor process compares
// the status every cycle, and it compares a result on each accepted handshake.
module tb_glob_acc_et_maxpool;

  localparam int IN_W  = 12;
  localparam int ACC_W = 16;
  localparam int RI_W  = 6;
  localparam int VMIN  = -32768;
  localparam int VMAX  = 32767;

  logic                    CLK = 1'b0;
  logic                    RESET = 1'b1;
  logic signed [IN_W-1:0]  psum_in = '0;
  logic                    glbctr_latch = 1'b0;
  logic                    mxpl_latch = 1'b0;
  logic                    mxpl_clr = 1'b0;
  logic        [RI_W-1:0]  ri_in = '0;
  logic                    et_l1_en = 1'b0;
  logic                    et_l1_clr = 1'b0;
  logic signed [ACC_W-1:0] et_thr = '0;
  logic                    et_l3_en = 1'b0;
  logic                    compute_done = 1'b0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_max;
  logic        [RI_W-1:0]  out_ri;
  logic                    et_flag;
  logic                    et_stop;
  logic                    ovf_err;

  glob_acc_et_maxpool #(.IN_W(IN_W), .ACC_W(ACC_W), .RI_W(RI_W)) dut (
    .CLK(CLK), .RESET(RESET), .psum_in(psum_in), .glbctr_latch(glbctr_latch),
    .mxpl_latch(mxpl_latch), .mxpl_clr(mxpl_clr), .ri_in(ri_in),
    .et_l1_en(et_l1_en), .et_l1_clr(et_l1_clr), .et_thr(et_thr),
    .et_l3_en(et_l3_en), .compute_done(compute_done), .out_ready(out_ready),
    .out_valid(out_valid), .out_max(out_max), .out_ri(out_ri),
    .et_flag(et_flag), .et_stop(et_stop), .ovf_err(ovf_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit glb; int psum; bit mlat; bit mclr; int ri;
    bit l1en; bit l1clr; int thr; bit l3; bit done; bit rdy;
  } stim_t;
  typedef struct { int v; int ri; } row_t;
  typedef struct { int due; bit flag; bit stop; bit ovf; bit vld; int mx; int ri; } stat_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    monOn = 1'b0;

  // Reference model: plain integers and a list of pooled rows
  int    mAcc;
  row_t  rows[$];
  bit    mFlag, mStop, mPending, mOvf;
  int    mOutMax, mOutRi;
  stat_t statQ[$];
  row_t  resQ[$];

  // Count rising edges so that queued status entries know when they are due.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic modelReset();
    mAcc = 0; rows.delete(); mFlag = 0; mStop = 0; mPending = 0; mOvf = 0;
    mOutMax = 0; mOutRi = 0; statQ.delete(); resQ.delete();
  endtask

  task automatic modelStep(input stim_t s);
    int    cand;
    bit    cond;
    row_t  best;
    stat_t st;
    cand = s.glb ? sat(mAcc + s.psum) : mAcc;
    if (s.mclr) rows.delete();
    if (s.mlat) rows.push_back('{v: cand, ri: s.ri});
    mAcc  = s.mlat ? 0 : cand;
    cond  = (cand < s.thr);
    mStop = s.l3 && mFlag;
    if (s.l1clr) mFlag = s.l1en ? cond : 1'b0;
    else if (s.l1en) mFlag = mFlag | cond;
    if (s.done) begin
      if (!mPending || s.rdy) begin
        best = '{v: VMIN, ri: 0};
        foreach (rows[i]) if (i == 0 || rows[i].v > best.v) best = rows[i];
        mPending = 1'b1; mOutMax = best.v; mOutRi = best.ri;
        resQ.push_back(best);
      end else begin
        mOvf = 1'b1;
      end
    end else if (mPending && s.rdy) begin
      mPending = 1'b0;
    end
    st = '{due: cyc + 1, flag: mFlag, stop: mStop, ovf: mOvf, vld: mPending,
           mx: mOutMax, ri: mOutRi};
    statQ.push_back(st);
  endtask

  task automatic driveNow(input stim_t s);
    glbctr_latch = s.glb;  psum_in = s.psum[IN_W-1:0];
    mxpl_latch = s.mlat;   mxpl_clr = s.mclr;   ri_in = s.ri[RI_W-1:0];
    et_l1_en = s.l1en;     et_l1_clr = s.l1clr; et_thr = s.thr[ACC_W-1:0];
    et_l3_en = s.l3;       compute_done = s.done; out_ready = s.rdy;
    modelStep(s);
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge CLK);
    #1;
    driveNow(s);
  endtask

  task automatic addPsum(input int p, input bit rdy = 1'b1);
    stim_t s;
    s = idle(); s.glb = 1'b1; s.psum = p; s.rdy = rdy;
    applyStimulus(s);
  endtask

  task automatic poolRow(input int r, input bit clr);
    stim_t s;
    s = idle(); s.mlat = 1'b1; s.mclr = clr; s.ri = r;
    applyStimulus(s);
  endtask

  task automatic publish(input bit rdy);
    stim_t s;
    s = idle(); s.done = 1'b1; s.rdy = rdy;
    applyStimulus(s);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_max"}, int'(out_max), 0);
    checkOutput({tag, "_out_ri"}, int'(out_ri), 0);
    checkOutput({tag, "_et_flag"}, int'(et_flag), 0);
    checkOutput({tag, "_et_stop"}, int'(et_stop), 0);
    checkOutput({tag, "_ovf_err"}, int'(ovf_err), 0);
  endtask

  // Release reset just after an edge and start the model on a fresh window.
  task automatic releaseReset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    monOn = 1'b1;
    driveNow(idle());
  endtask

  // Monitor: compare the status entries that are due, and pop one expected
  // result on every accepted handshake.
  always @(negedge CLK) begin
    if (monOn) begin
      while (statQ.size() > 0 && statQ[0].due <= cyc) begin
        stat_t st;
        st = statQ.pop_front();
        if (st.due == cyc) begin
          checkOutput("et_flag", int'(et_flag), int'(st.flag));
          checkOutput("et_stop", int'(et_stop), int'(st.stop));
          checkOutput("ovf_err", int'(ovf_err), int'(st.ovf));
          checkOutput("out_valid", int'(out_valid), int'(st.vld));
          if (st.vld) begin
            checkOutput("out_max_hold", int'(out_max), st.mx);
            checkOutput("out_ri_hold", int'(out_ri), st.ri);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (resQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          row_t r;
          r = resQ.pop_front();
          checkOutput("result_max", int'(out_max), r.v);
          checkOutput("result_ri", int'(out_ri), r.ri);
        end
      end
    end
  end

  initial begin
    stim_t s;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkResetOutputs("reset");
    releaseReset();

    // Accumulate 5, 7, -3 and pool as row 4 (expect 9 @ 4)
    addPsum(5); addPsum(7); addPsum(-3);
    poolRow(4, 1'b0);
    publish(1'b1);
    applyStimulus(idle());

    // Positive saturation: 16*2047 + 8 = 32760, then +100 clamps at 32767
    repeat (16) addPsum(2047);
    addPsum(8); addPsum(100);
    poolRow(5, 1'b1);
    publish(1'b1);
    // Negative saturation: -32000, then -2048 steps clamp at -32768
    repeat (15) addPsum(-2048);
    addPsum(-1280);
    repeat (3) addPsum(-2048);
    poolRow(6, 1'b1);
    publish(1'b1);

    // A tie keeps the earlier row, then clear and latch in the same cycle
    addPsum(10); poolRow(1, 1'b1);
    addPsum(10); poolRow(2, 1'b0);
    addPsum(-5); poolRow(3, 1'b0);
    publish(1'b1);
    s = idle(); s.glb = 1'b1; s.psum = -7; s.mlat = 1'b1; s.mclr = 1'b1; s.ri = 9;
    applyStimulus(s);
    publish(1'b1);
    // A final latch in the same cycle as compute_done is included
    s = idle(); s.glb = 1'b1; s.psum = 300; s.mlat = 1'b1; s.ri = 12; s.done = 1'b1;
    applyStimulus(s);

    // ET: cand 15 < 20 sets the flag, so l3 yields one stop pulse
    s = idle(); s.glb = 1'b1; s.psum = 15; s.l1en = 1'b1; s.thr = 20;
    applyStimulus(s);
    s = idle(); s.l3 = 1'b1; applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());
    // Clear together with enable at cand 25 reloads the flag to 0
    s = idle(); s.glb = 1'b1; s.psum = 10; s.l1en = 1'b1; s.l1clr = 1'b1; s.thr = 20;
    applyStimulus(s);
    s = idle(); s.l3 = 1'b1; applyStimulus(s);
    applyStimulus(idle());
    poolRow(0, 1'b1);

    // Handshake: hold ready low, a second done is dropped, and a third done
    // with ready high goes back to back
    addPsum(42, 1'b0);
    s = idle(); s.mlat = 1'b1; s.mclr = 1'b1; s.ri = 7; s.rdy = 1'b0; applyStimulus(s);
    publish(1'b0);
    addPsum(99, 1'b0);
    s = idle(); s.mlat = 1'b1; s.ri = 8; s.rdy = 1'b0; applyStimulus(s);
    publish(1'b0);
    addPsum(500, 1'b0);
    s = idle(); s.mlat = 1'b1; s.ri = 11; s.rdy = 1'b0; applyStimulus(s);
    publish(1'b1);
    applyStimulus(idle());
    applyStimulus(idle());

    // Asynchronous reset mid-window with acc, flag and a pending output
    addPsum(50, 1'b0);
    s = idle(); s.l1en = 1'b1; s.thr = 100; s.rdy = 1'b0; applyStimulus(s);
    publish(1'b0);
    @(posedge CLK);
    #3;
    monOn = 1'b0;
    RESET = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    modelReset();
    releaseReset();
    publish(1'b1);
    applyStimulus(idle());

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.glb   = ($urandom_range(0, 9) < 7);
      s.psum  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) - 2048
                                            : int'($urandom_range(0, 200)) - 100;
      s.mlat  = ($urandom_range(0, 9) < 2);
      s.mclr  = ($urandom_range(0, 99) < 8);
      s.ri    = int'($urandom_range(0, 63));
      s.l1en  = ($urandom_range(0, 9) < 2);
      s.l1clr = ($urandom_range(0, 9) < 1);
      s.thr   = int'($urandom_range(0, 6000)) - 3000;
      s.l3    = ($urandom_range(0, 9) < 2);
      s.done  = ($urandom_range(0, 9) < 1);
      s.rdy   = ($urandom_range(0, 9) < 6);
      applyStimulus(s);
    end

    repeat (5) applyStimulus(idle());
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("results_drained", resQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
